// File: rtl/fruit_pkg.sv
// Shared definitions for the fruit sprite engine: fruit choices, slot states,
// sprite geometry, per-fruit colours and the 17-row shape table.
package fruit_pkg;

  typedef enum logic [1:0] {
    CHOICE_ORANGE      = 2'd0,
    CHOICE_APPLE       = 2'd1,
    CHOICE_POMEGRANATE = 2'd2,
    CHOICE_PEAR        = 2'd3
  } choice_e;

  typedef enum logic [1:0] {
    SLOT_EMPTY  = 2'd0,
    SLOT_WHOLE  = 2'd1,
    SLOT_SLICED = 2'd2
  } slot_state_e;

  localparam int SPRITE_HALF = 8;
  localparam int SPRITE_ROWS = 2 * SPRITE_HALF + 1;

  localparam logic [11:0] COLOR_ORANGE      = 12'hF88;
  localparam logic [11:0] COLOR_APPLE       = 12'hF00;
  localparam logic [11:0] COLOR_POMEGRANATE = 12'hFBE;
  // 12'hF90 is held back for a future fruit; the pear is drawn in green.
  localparam logic [11:0] COLOR_PEAR        = 12'h9F0;

  // Row masks, 17 rows per choice (index = choice*17 + row). Bit d set means
  // the pixels at horizontal distance d from the centre column are filled.
  // The base outline is a radius-8 disc; the other fruits alter its top rows.
  localparam logic [8:0] SHAPE_ROM [4*SPRITE_ROWS] = '{
    // orange: plain disc
    9'h001, 9'h00F, 9'h03F, 9'h07F, 9'h07F, 9'h0FF, 9'h0FF, 9'h0FF, 9'h1FF,
    9'h0FF, 9'h0FF, 9'h0FF, 9'h07F, 9'h07F, 9'h03F, 9'h00F, 9'h001,
    // apple: centre notch cut into the top rows
    9'h000, 9'h00C, 9'h03E, 9'h07F, 9'h07F, 9'h0FF, 9'h0FF, 9'h0FF, 9'h1FF,
    9'h0FF, 9'h0FF, 9'h0FF, 9'h07F, 9'h07F, 9'h03F, 9'h00F, 9'h001,
    // pomegranate: small crown of points on top
    9'h005, 9'h007, 9'h03F, 9'h07F, 9'h07F, 9'h0FF, 9'h0FF, 9'h0FF, 9'h1FF,
    9'h0FF, 9'h0FF, 9'h0FF, 9'h07F, 9'h07F, 9'h03F, 9'h00F, 9'h001,
    // pear: narrow neck widening into the disc body
    9'h001, 9'h003, 9'h003, 9'h007, 9'h007, 9'h00F, 9'h0FF, 9'h0FF, 9'h1FF,
    9'h0FF, 9'h0FF, 9'h0FF, 9'h07F, 9'h07F, 9'h03F, 9'h00F, 9'h001
  };

  function automatic logic [11:0] choice_color(input logic [1:0] c);
    case (choice_e'(c))
      CHOICE_ORANGE:      return COLOR_ORANGE;
      CHOICE_APPLE:       return COLOR_APPLE;
      CHOICE_POMEGRANATE: return COLOR_POMEGRANATE;
      default:            return COLOR_PEAR;
    endcase
  endfunction

  // Safe mask lookup: distances beyond the 9-bit mask read as empty.
  function automatic logic mask_bit(input logic [8:0] m, input logic [3:0] d);
    logic [8:0] s;
    s = m >> d;
    return s[0];
  endfunction

endpackage

// File: rtl/fruit_shape_rom.sv
// Combinational shape lookup.
//   choice : fruit choice (2 bits)
//   r      : sprite row 0..16; other values return an empty mask
//   mask   : 9-bit row mask, bit d = pixels at |dx| = d are filled
import fruit_pkg::*;

module fruit_shape_rom (
  input  logic [1:0] choice,
  input  logic [4:0] r,
  output logic [8:0] mask
);

  logic [6:0] idx;

  always_comb begin
    // max 3*17+31 = 82, fits in 7 bits; only used when r is in range
    idx  = 7'(choice) * 7'(SPRITE_ROWS) + {2'b00, r};
    mask = '0;
    if (r < 5'(SPRITE_ROWS)) mask = SHAPE_ROM[idx];
  end

endmodule

// File: rtl/fruit_sprite_engine.sv
// Fruit sprite engine: NUM_SLOTS fruit slots (load / slice / frame-tick
// animation) and a 2-stage pixel query pipeline.
//   clk, rst                       : clock, synchronous active-high reset
//   frame_tick                     : frame strobe, advances sliced fruit
//   load, load_slot/x0/y0/choice   : place a whole fruit in a slot
//   slice, slice_slot              : cut a whole fruit
//   en                             : display enable (sampled with the query)
//   valid_in, x, y                 : pixel query
//   valid_out, color, hit, hit_slot: query result, 2 cycles after valid_in
import fruit_pkg::*;

module fruit_sprite_engine #(
  parameter int NUM_SLOTS = 4,
  parameter int COORD_W   = 10,
  parameter int COLOR_W   = 12,
  parameter int SPLIT_MAX = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_tick,
  input  logic                         load,
  input  logic [$clog2(NUM_SLOTS)-1:0] load_slot,
  input  logic [COORD_W-1:0]           load_x0,
  input  logic [COORD_W-1:0]           load_y0,
  input  logic [1:0]                   load_choice,
  input  logic                         slice,
  input  logic [$clog2(NUM_SLOTS)-1:0] slice_slot,
  input  logic                         en,
  input  logic                         valid_in,
  input  logic [COORD_W-1:0]           x,
  input  logic [COORD_W-1:0]           y,
  output logic                         valid_out,
  output logic [COLOR_W-1:0]           color,
  output logic                         hit,
  output logic [$clog2(NUM_SLOTS)-1:0] hit_slot
);

  localparam int SLOT_W  = $clog2(NUM_SLOTS);
  localparam int SPLIT_W = $clog2(SPLIT_MAX + 1);
  localparam int CW1     = COORD_W + 1;
  localparam logic [CW1-1:0]        HALF_U  = CW1'(SPRITE_HALF);
  localparam logic signed [CW1-1:0] ROW_MAX = CW1'(2 * SPRITE_HALF);

  slot_state_e        state_q [NUM_SLOTS], state_d [NUM_SLOTS];
  logic [SPLIT_W-1:0] split_q [NUM_SLOTS], split_d [NUM_SLOTS];
  logic [COORD_W-1:0] x0_q    [NUM_SLOTS], x0_d    [NUM_SLOTS];
  logic [COORD_W-1:0] y0_q    [NUM_SLOTS], y0_d    [NUM_SLOTS];
  logic [1:0]         choice_q[NUM_SLOTS], choice_d[NUM_SLOTS];

  logic [NUM_SLOTS-1:0] hit_now;
  logic [COLOR_W-1:0]   color_now [NUM_SLOTS];

  logic                 valid1_q, valid1_d, en1_q, en1_d;
  logic [NUM_SLOTS-1:0] hit1_q, hit1_d;
  logic [COLOR_W-1:0]   color1_q [NUM_SLOTS], color1_d [NUM_SLOTS];

  logic                 valid2_q, valid2_d, hit2_q, hit2_d;
  logic [COLOR_W-1:0]   color2_q, color2_d;
  logic [SLOT_W-1:0]    slot2_q, slot2_d;

  // Slot update priority: load > slice > frame tick. A slice only acts on a
  // WHOLE slot and the tick only on SLICED ones, so slice-vs-tick in the same
  // cycle naturally leaves split=0.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i]  = state_q[i];
      split_d[i]  = split_q[i];
      x0_d[i]     = x0_q[i];
      y0_d[i]     = y0_q[i];
      choice_d[i] = choice_q[i];
      if (frame_tick && state_q[i] == SLOT_SLICED) begin
        if (split_q[i] == SPLIT_W'(SPLIT_MAX)) begin
          state_d[i] = SLOT_EMPTY;
          split_d[i] = '0;
        end else begin
          split_d[i] = split_q[i] + SPLIT_W'(1);
        end
      end
      if (slice && slice_slot == SLOT_W'(i) && state_q[i] == SLOT_WHOLE) begin
        state_d[i] = SLOT_SLICED;
        split_d[i] = '0;
      end
      if (load && load_slot == SLOT_W'(i)) begin
        state_d[i]  = SLOT_WHOLE;
        split_d[i]  = '0;
        x0_d[i]     = load_x0;
        y0_d[i]     = load_y0;
        choice_d[i] = load_choice;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic signed [CW1-1:0] row_s;
    logic                  row_ok;
    logic [4:0]            row;
    logic [8:0]            mask_l, mask_r;
    logic [CW1-1:0]        xe, x0e, sp, xs_l, xs_r, d_w, d_l, d_r;
    logic                  hit_w, hit_l, hit_r, hit_slot_now;

    always_comb begin
      row_s  = $signed({1'b0, y}) - $signed({1'b0, y0_q[gi]}) + CW1'(SPRITE_HALF);
      row_ok = !row_s[CW1-1] && (row_s <= ROW_MAX);
      row    = row_s[4:0];
    end

    fruit_shape_rom u_rom_l (.choice(choice_q[gi]), .r(row), .mask(mask_l));
    fruit_shape_rom u_rom_r (.choice(choice_q[gi]), .r(row), .mask(mask_r));

    // All horizontal maths in COORD_W+1 unsigned bits with explicit range
    // checks, so neither half can wrap across the screen edge.
    always_comb begin
      xe    = {1'b0, x};
      x0e   = {1'b0, x0_q[gi]};
      sp    = CW1'(split_q[gi]);
      d_w   = (xe >= x0e) ? xe - x0e : x0e - xe;
      hit_w = (d_w <= HALF_U) && mask_bit(mask_l, d_w[3:0]);
      xs_l  = xe + sp;
      d_l   = x0e - xs_l;
      hit_l = (xs_l < x0e) && (d_l <= HALF_U) && mask_bit(mask_l, d_l[3:0]);
      xs_r  = xe - sp;
      d_r   = xs_r - x0e;
      hit_r = (xe >= sp) && (xs_r >= x0e) && (d_r <= HALF_U) &&
              mask_bit(mask_r, d_r[3:0]);
      case (state_q[gi])
        SLOT_WHOLE:  hit_slot_now = row_ok && hit_w;
        SLOT_SLICED: hit_slot_now = row_ok && (hit_l || hit_r);
        default:     hit_slot_now = 1'b0;
      endcase
    end

    assign hit_now[gi]   = hit_slot_now;
    assign color_now[gi] = COLOR_W'(choice_color(choice_q[gi]));
  end

  always_comb begin
    valid1_d = valid_in;
    en1_d    = en;
    hit1_d   = valid_in ? hit_now : '0;
    color1_d = color_now;
  end

  // Descending scan so the lowest-index hitting slot wins.
  always_comb begin
    valid2_d = valid1_q;
    hit2_d   = 1'b0;
    color2_d = '0;
    slot2_d  = '0;
    if (valid1_q && en1_q) begin
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
        if (hit1_q[i]) begin
          hit2_d   = 1'b1;
          color2_d = color1_q[i];
          slot2_d  = SLOT_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i]  <= SLOT_EMPTY;
        split_q[i]  <= '0;
        x0_q[i]     <= '0;
        y0_q[i]     <= '0;
        choice_q[i] <= '0;
        color1_q[i] <= '0;
      end
      valid1_q <= 1'b0;
      en1_q    <= 1'b0;
      hit1_q   <= '0;
      valid2_q <= 1'b0;
      hit2_q   <= 1'b0;
      color2_q <= '0;
      slot2_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i]  <= state_d[i];
        split_q[i]  <= split_d[i];
        x0_q[i]     <= x0_d[i];
        y0_q[i]     <= y0_d[i];
        choice_q[i] <= choice_d[i];
        color1_q[i] <= color1_d[i];
      end
      valid1_q <= valid1_d;
      en1_q    <= en1_d;
      hit1_q   <= hit1_d;
      valid2_q <= valid2_d;
      hit2_q   <= hit2_d;
      color2_q <= color2_d;
      slot2_q  <= slot2_d;
    end
  end

  assign valid_out = valid2_q;
  assign color     = color2_q;
  assign hit       = hit2_q;
  assign hit_slot  = slot2_q;

endmodule

// File: tb/tb_fruit_sprite_engine.sv
// Directed bench for fruit_sprite_engine with hand-computed expectations.
module tb_fruit_sprite_engine;

  logic        clk = 1'b0;
  logic        rst, frame_tick, load, slice, en, valid_in;
  logic [1:0]  load_slot, slice_slot, load_choice, hit_slot;
  logic [9:0]  load_x0, load_y0, x, y;
  logic        valid_out, hit;
  logic [11:0] color;

  int tests = 0;
  int fails = 0;

  fruit_sprite_engine dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .load(load), .load_slot(load_slot), .load_x0(load_x0), .load_y0(load_y0),
    .load_choice(load_choice), .slice(slice), .slice_slot(slice_slot),
    .en(en), .valid_in(valid_in), .x(x), .y(y),
    .valid_out(valid_out), .color(color), .hit(hit), .hit_slot(hit_slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [1:0] s, input logic [9:0] lx, input logic [9:0] ly,
                         input logic [1:0] c);
    @(negedge clk);
    load = 1'b1; load_slot = s; load_x0 = lx; load_y0 = ly; load_choice = c;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_slice(input logic [1:0] s);
    @(negedge clk);
    slice = 1'b1; slice_slot = s;
    @(negedge clk);
    slice = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  // Single query; checks nothing arrives after 1 cycle and the result after 2.
  task automatic query(input string tag, input logic [9:0] qx, input logic [9:0] qy,
                       input logic eh, input logic [11:0] ec, input logic [1:0] es);
    @(negedge clk);
    valid_in = 1'b1; x = qx; y = qy;
    @(posedge clk); #1;
    chk({tag, ".lat1"}, 32'(valid_out), 32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".valid"}, 32'(valid_out), 32'd1);
    chk({tag, ".hit"},   32'(hit),       32'(eh));
    chk({tag, ".color"}, 32'(color),     32'(ec));
    chk({tag, ".slot"},  32'(hit_slot),  32'(es));
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; load = 1'b0; slice = 1'b0; en = 1'b1;
    valid_in = 1'b0; load_slot = '0; slice_slot = '0; load_choice = '0;
    load_x0 = '0; load_y0 = '0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.valid", 32'(valid_out), 32'd0);
    chk("rst.hit",   32'(hit),       32'd0);
    chk("rst.color", 32'(color),     32'd0);
    chk("rst.slot",  32'(hit_slot),  32'd0);
    rst = 1'b0;

    query("empty", 10'd100, 10'd100, 1'b0, 12'h000, 2'd0);

    // Whole orange, edges of the disc
    do_load(2'd0, 10'd100, 10'd100, 2'd0);
    query("or.x108", 10'd108, 10'd100, 1'b1, 12'hF88, 2'd0);
    query("or.x109", 10'd109, 10'd100, 1'b0, 12'h000, 2'd0);
    query("or.r1",   10'd100, 10'd93,  1'b1, 12'hF88, 2'd0);
    query("or.rneg", 10'd100, 10'd91,  1'b0, 12'h000, 2'd0);
    query("or.r16",  10'd100, 10'd108, 1'b1, 12'hF88, 2'd0);
    query("or.r16b", 10'd101, 10'd108, 1'b0, 12'h000, 2'd0);
    query("or.r17",  10'd100, 10'd109, 1'b0, 12'h000, 2'd0);

    // Overlap: lowest slot wins
    do_load(2'd1, 10'd100, 10'd100, 2'd1);
    query("prio", 10'd100, 10'd100, 1'b1, 12'hF88, 2'd0);

    // Apple notch at (500,500)
    do_load(2'd1, 10'd500, 10'd500, 2'd1);
    query("ap.ctr",  10'd500, 10'd500, 1'b1, 12'hF00, 2'd1);
    query("ap.r0",   10'd500, 10'd492, 1'b0, 12'h000, 2'd0);
    query("ap.r1d0", 10'd500, 10'd493, 1'b0, 12'h000, 2'd0);
    query("ap.r1d2", 10'd502, 10'd493, 1'b1, 12'hF00, 2'd1);

    // Pear then pomegranate crown in slot 3
    do_load(2'd3, 10'd300, 10'd300, 2'd3);
    query("pear", 10'd300, 10'd300, 1'b1, 12'h9F0, 2'd3);
    do_load(2'd3, 10'd600, 10'd600, 2'd2);
    query("pom.d0", 10'd600, 10'd592, 1'b1, 12'hFBE, 2'd3);
    query("pom.d1", 10'd601, 10'd592, 1'b0, 12'h000, 2'd0);
    query("pom.d2", 10'd602, 10'd592, 1'b1, 12'hFBE, 2'd3);

    // Slice slot 0, split = 3: halves at x<=96 and x>=103
    do_slice(2'd0);
    ticks(3);
    query("sl.x96",  10'd96,  10'd100, 1'b1, 12'hF88, 2'd0);
    query("sl.x100", 10'd100, 10'd100, 1'b0, 12'h000, 2'd0);
    query("sl.x103", 10'd103, 10'd100, 1'b1, 12'hF88, 2'd0);
    query("sl.x89",  10'd89,  10'd100, 1'b1, 12'hF88, 2'd0);
    query("sl.x88",  10'd88,  10'd100, 1'b0, 12'h000, 2'd0);
    // A second slice on a SLICED slot must not reset split
    do_slice(2'd0);
    query("sl.again97", 10'd97, 10'd100, 1'b0, 12'h000, 2'd0);
    query("sl.again96", 10'd96, 10'd100, 1'b1, 12'hF88, 2'd0);

    // Fresh slice, 15 ticks keeps it alive at split 15, the 16th empties it
    do_load(2'd0, 10'd100, 10'd100, 2'd0);
    do_slice(2'd0);
    ticks(15);
    query("sp15.x84", 10'd84, 10'd100, 1'b1, 12'hF88, 2'd0);
    ticks(1);
    query("gone.x84",  10'd84,  10'd100, 1'b0, 12'h000, 2'd0);
    query("gone.x100", 10'd100, 10'd100, 1'b0, 12'h000, 2'd0);

    // Load + slice same cycle: load wins, so a tick leaves the centre filled
    @(negedge clk);
    load = 1'b1; load_slot = 2'd0; load_x0 = 10'd100; load_y0 = 10'd100;
    load_choice = 2'd0; slice = 1'b1; slice_slot = 2'd0;
    @(negedge clk);
    load = 1'b0; slice = 1'b0;
    ticks(1);
    query("ldsl.whole", 10'd100, 10'd100, 1'b1, 12'hF88, 2'd0);

    // Slice + tick same cycle: split stays 0 (centre still filled)
    @(negedge clk);
    slice = 1'b1; slice_slot = 2'd0; frame_tick = 1'b1;
    @(negedge clk);
    slice = 1'b0; frame_tick = 1'b0;
    query("sltk.sp0", 10'd100, 10'd100, 1'b1, 12'hF88, 2'd0);
    ticks(1);
    query("sltk.sp1", 10'd100, 10'd100, 1'b0, 12'h000, 2'd0);

    // Screen-edge fruit at (3,3): no wrap-around hits
    do_load(2'd2, 10'd3, 10'd3, 2'd0);
    query("edge.00",   10'd0,    10'd0,    1'b1, 12'hF88, 2'd2);
    query("edge.wrx",  10'd1020, 10'd3,    1'b0, 12'h000, 2'd0);
    query("edge.wry",  10'd3,    10'd1020, 1'b0, 12'h000, 2'd0);
    do_slice(2'd2);
    ticks(5);
    query("edge.x1",   10'd1,    10'd3,    1'b0, 12'h000, 2'd0);
    query("edge.x8",   10'd8,    10'd3,    1'b1, 12'hF88, 2'd2);
    query("edge.x1023",10'd1023, 10'd3,    1'b0, 12'h000, 2'd0);

    // Display disabled
    en = 1'b0;
    query("en0", 10'd8, 10'd3, 1'b0, 12'h000, 2'd0);
    en = 1'b1;

    // Streaming queries through a one-cycle reset
    @(negedge clk);
    valid_in = 1'b1; x = 10'd500; y = 10'd500;
    @(posedge clk);
    @(posedge clk); #1;
    chk("strm.pre.valid", 32'(valid_out), 32'd1);
    chk("strm.pre.hit",   32'(hit),       32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("strm.r0.valid", 32'(valid_out), 32'd0);
    chk("strm.r0.hit",   32'(hit),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("strm.r1.valid", 32'(valid_out), 32'd0);
    @(posedge clk); #1;
    chk("strm.r2.valid", 32'(valid_out), 32'd1);
    chk("strm.r2.hit",   32'(hit),       32'd0);
    chk("strm.r2.color", 32'(color),     32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    query("post.slot1", 10'd500, 10'd500, 1'b0, 12'h000, 2'd0);
    query("post.slot3", 10'd600, 10'd600, 1'b0, 12'h000, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
